wb_uart_tx: RTL and testbench

//  Wishbone-pipelined bus slave for the UART window (0xFFFF_FFF8..0xFFFF_FFFF, 2 words).

---
 rtl/wb_uart_tx.sv | 223 ++++++++++++++++++++++
 tb/tb_wb_uart_tx.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_uart_tx.sv
// wb_uart_tx: Wishbone-pipelined slave for the two-word UART window.
// DATA writes queue bytes in a TX FIFO; an 8N1 serializer drains it onto o_uart_tx.
module wb_uart_tx #(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned DEFAULT_DIV = 434
) (
    input  logic        i_clk,
    input  logic        i_resetn,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic        i_wb_addr,
    input  logic [31:0] i_wb_data,
    input  logic [3:0]  i_wb_sel,
    output logic        o_wb_ack,
    output logic        o_wb_stall,
    output logic [31:0] o_wb_data,
    output logic        o_uart_tx,
    output logic        o_irq
);

    localparam int unsigned PW      = $clog2(FIFO_DEPTH);
    localparam int unsigned CW      = PW + 1;
    localparam logic [15:0] MIN_DIV = 16'd16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    // Bus-side state
    logic          ack_q, ack_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [15:0]   div_q, div_d;
    logic          ovf_q, ovf_d;

    // FIFO state
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Serializer state
    state_e        state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [15:0]   frame_div_q, frame_div_d;
    logic [15:0]   baud_q, baud_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic          tx_q, tx_d;

    logic          req;
    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic          baud_zero;
    logic [4:0]    count_field;
    logic          unused_bits;

    assign req         = i_wb_cyc && i_wb_stb;
    assign fifo_full   = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty  = (count_q == '0);
    assign push_req    = req && i_wb_we && !i_wb_addr && i_wb_sel[0];
    // Fullness is taken from the registered count, so a same-cycle pop never frees a slot for this push.
    assign push_ok     = push_req && !fifo_full;
    assign baud_zero   = (baud_q == '0);
    assign count_field = 5'(count_q);
    assign unused_bits = ^{i_wb_data[30:16], i_wb_sel[2]};

    // ------------------------------------------------------------------
    // Serializer: start bit, 8 data bits LSB first, stop bit.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned, which would infer a latch.
        state_d     = state_q;
        shift_d     = shift_q;
        frame_div_d = frame_div_q;
        baud_d      = baud_q;
        bit_cnt_d   = bit_cnt_q;
        pop         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    shift_d     = fifo_mem[rd_ptr_q];
                    frame_div_d = div_q;
                    baud_d      = div_q - 16'd1;
                    bit_cnt_d   = '0;
                    state_d     = S_START;
                end
            end
            S_START: begin
                if (baud_zero) begin
                    baud_d  = frame_div_q - 16'd1;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            S_DATA: begin
                if (baud_zero) begin
                    baud_d    = frame_div_q - 16'd1;
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            S_STOP: begin
                if (baud_zero) begin
                    state_d = S_IDLE;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The line is registered from the next state so it changes on the same edge as the FSM.
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Bus decode, control registers and FIFO pointers.
    // ------------------------------------------------------------------
    always_comb begin
        ack_d    = req;
        rdata_d  = '0;
        div_d    = div_q;
        ovf_d    = ovf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (req && !i_wb_we && i_wb_addr) begin
            rdata_d = {ovf_q, 7'h0, 3'h0, count_field, div_q};
        end

        if (req && i_wb_we && i_wb_addr) begin
            if (i_wb_sel[1:0] == 2'b11) begin
                div_d = (i_wb_data[15:0] < MIN_DIV) ? MIN_DIV : i_wb_data[15:0];
            end
            if (i_wb_sel[3] && i_wb_data[31]) begin
                ovf_d = 1'b0;
            end
        end

        if (push_req && fifo_full) begin
            ovf_d = 1'b1;
        end

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            ack_q       <= 1'b0;
            rdata_q     <= '0;
            div_q       <= 16'(DEFAULT_DIV);
            ovf_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= S_IDLE;
            shift_q     <= '0;
            frame_div_q <= 16'(DEFAULT_DIV);
            baud_q      <= '0;
            bit_cnt_q   <= '0;
            tx_q        <= 1'b1;
        end else begin
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            div_q       <= div_d;
            ovf_q       <= ovf_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            shift_q     <= shift_d;
            frame_div_q <= frame_div_d;
            baud_q      <= baud_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_q        <= tx_d;
        end
    end

    // NOTE: the storage array has no reset; emptiness is tracked by count_q, so stale bytes are never read.
    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= i_wb_data[7:0];
        end
    end

    assign o_wb_ack   = ack_q;
    assign o_wb_stall = 1'b0;
    assign o_wb_data  = rdata_q;
    assign o_uart_tx  = tx_q;
    assign o_irq      = fifo_empty && (state_q == S_IDLE);

endmodule

// File: tb/tb_wb_uart_tx.sv
// Self-checking bench for wb_uart_tx: directed scenarios plus a randomized phase,
// scored against a byte-queue model and a per-clock frame decoder on the serial line.
module tb_wb_uart_tx;

    localparam int DEPTH   = 16;
    localparam int DEF_DIV = 434;

    logic        i_clk = 1'b0;
    logic        i_resetn = 1'b0;
    logic        i_wb_cyc = 1'b0;
    logic        i_wb_stb = 1'b0;
    logic        i_wb_we = 1'b0;
    logic        i_wb_addr = 1'b0;
    logic [31:0] i_wb_data = '0;
    logic [3:0]  i_wb_sel = '0;
    logic        o_wb_ack;
    logic        o_wb_stall;
    logic [31:0] o_wb_data;
    logic        o_uart_tx;
    logic        o_irq;

    always #5 i_clk = ~i_clk;

    wb_uart_tx #(
        .FIFO_DEPTH (DEPTH),
        .DEFAULT_DIV(DEF_DIV)
    ) dut (
        .i_clk     (i_clk),
        .i_resetn  (i_resetn),
        .i_wb_cyc  (i_wb_cyc),
        .i_wb_stb  (i_wb_stb),
        .i_wb_we   (i_wb_we),
        .i_wb_addr (i_wb_addr),
        .i_wb_data (i_wb_data),
        .i_wb_sel  (i_wb_sel),
        .o_wb_ack  (o_wb_ack),
        .o_wb_stall(o_wb_stall),
        .o_wb_data (o_wb_data),
        .o_uart_tx (o_uart_tx),
        .o_irq     (o_irq)
    );

    int          n_cmp = 0;
    int          n_fail = 0;
    int unsigned cyc_cnt = 0;

    always @(posedge i_clk) cyc_cnt <= cyc_cnt + 1;

    // Reference model: bytes accepted but not yet seen on the line, plus register shadows.
    logic [7:0]  exp_q[$];
    int          n_acc, n_started, n_done;
    logic        model_ovf;
    int          model_div, model_div_old;
    int unsigned div_cyc;
    logic        mon_on;

    task automatic model_reset();
        exp_q.delete();
        n_acc         = 0;
        n_started     = 0;
        n_done        = 0;
        model_ovf     = 1'b0;
        model_div     = DEF_DIV;
        model_div_old = DEF_DIV;
        div_cyc       = 32'hFFFF_FFFF;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] status_exp();
        return {model_ovf, 7'h0, 3'h0, 5'(n_acc - n_started), 16'(model_div)};
    endfunction

    // One pipelined transfer: request sampled on one edge, ack and data checked just after it.
    task automatic bus(input logic w, input logic a, input logic [31:0] d, input logic [3:0] s,
                       input string tag, output logic [31:0] rd);
        logic [31:0] exp_rd;
        @(negedge i_clk);
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = w; i_wb_addr = a; i_wb_data = d; i_wb_sel = s;
        @(posedge i_clk);
        #1;
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
        exp_rd = (!w && a) ? status_exp() : 32'h0;
        if (w && !a && s[0]) begin
            if (n_acc - n_started < DEPTH) begin
                n_acc++;
                exp_q.push_back(d[7:0]);
            end else begin
                model_ovf = 1'b1;
            end
        end
        if (w && a) begin
            if (s[1:0] == 2'b11) begin
                model_div_old = model_div;
                model_div     = (int'(d[15:0]) < 16) ? 16 : int'(d[15:0]);
                div_cyc       = cyc_cnt;
            end
            if (s[3] && d[31]) model_ovf = 1'b0;
        end
        rd = o_wb_data;
        check({tag, "_ack"}, 32'(o_wb_ack), 32'd1);
        check({tag, "_rdata"}, o_wb_data, exp_rd);
    endtask

    task automatic wait_fall(output int unsigned t, input int budget);
        int k = 0;
        do begin
            @(negedge i_clk);
            k++;
        end while (o_uart_tx !== 1'b0 && k < budget);
        check("start_edge", 32'(o_uart_tx), 32'd0);
        t = cyc_cnt;
    endtask

    task automatic wait_until(input int unsigned target);
        while (cyc_cnt < target) @(negedge i_clk);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int k = 0;
        while (n_done != n_acc && k < budget) begin
            @(negedge i_clk);
            k++;
        end
        check({tag, "_drained"}, 32'(n_done), 32'(n_acc));
        @(negedge i_clk);
        check({tag, "_irq_idle"}, 32'(o_irq), 32'd1);
        check({tag, "_line_idle"}, 32'(o_uart_tx), 32'd1);
    endtask

    // Line decoder: on each start bit take the next expected byte and compare every clock of the frame.
    always begin : monitor
        logic [9:0] bits;
        logic [7:0] exp_byte;
        logic       bad_val;
        logic       bit_ok;
        logic       aborted;
        int         fd;
        int         frame_no;
        @(negedge i_clk);
        if (mon_on && i_resetn === 1'b1 && o_uart_tx === 1'b0) begin
            fd = (div_cyc == cyc_cnt) ? model_div_old : model_div;
            n_cmp++;
            assert (exp_q.size() > 0) else begin
                n_fail++;
                $error("FAIL spurious_start: observed start bit with %0d bytes pending, expected >0", exp_q.size());
            end
            exp_byte = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
            n_started++;
            frame_no = n_started;
            bits     = {1'b1, exp_byte, 1'b0};
            aborted  = 1'b0;
            for (int b = 0; b < 10 && !aborted; b++) begin
                bit_ok  = 1'b1;
                bad_val = bits[b];
                for (int c = 0; c < fd && !aborted; c++) begin
                    if (b != 0 || c != 0) @(negedge i_clk);
                    if (!mon_on) begin
                        aborted = 1'b1;
                    end else if (o_uart_tx !== bits[b] && bit_ok) begin
                        bit_ok  = 1'b0;
                        bad_val = o_uart_tx;
                    end
                end
                if (!aborted) begin
                    n_cmp++;
                    assert (bit_ok) else begin
                        n_fail++;
                        $error("FAIL frame%0d_bit%0d: observed=%b expected=%b (byte 0x%02h, div %0d)",
                               frame_no, b, bad_val, bits[b], exp_byte, fd);
                    end
                end
            end
            if (!aborted) n_done++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] d;
        logic [3:0]  s;
        logic [9:0]  fb;
        logic        all_high;
        int unsigned t0;

        model_reset();
        mon_on   = 1'b1;
        i_resetn = 1'b0;

        // Reset state and single-cycle ack
        repeat (3) @(negedge i_clk);
        check("t1_reset_tx", 32'(o_uart_tx), 32'd1);
        check("t1_reset_ack", 32'(o_wb_ack), 32'd0);
        i_resetn = 1'b1;
        @(negedge i_clk);
        check("t1_irq", 32'(o_irq), 32'd1);
        check("t1_stall", 32'(o_wb_stall), 32'd0);
        bus(1'b0, 1'b1, 32'h0, 4'hF, "t1_status", rd);
        check("t1_status_lit", rd, 32'h0000_01B2);
        @(posedge i_clk);
        #1;
        check("t1_ack_drop", 32'(o_wb_ack), 32'd0);
        check("t1_data_idle", o_wb_data, 32'd0);
        bus(1'b0, 1'b0, 32'h0, 4'hF, "t1_data_read", rd);

        // Single frame at div 16
        bus(1'b1, 1'b1, 32'd16, 4'b0011, "t2_div", rd);
        bus(1'b1, 1'b0, 32'h55, 4'b0001, "t2_push", rd);
        wait_fall(t0, 8);
        check("t2_irq_busy", 32'(o_irq), 32'd0);
        wait_drain("t2", 400);
        bus(1'b1, 1'b0, 32'hAA, 4'b0000, "t2_sel0_off", rd);
        bus(1'b0, 1'b1, 32'h0, 4'hF, "t2_status", rd);

        // 17 bytes with the first in flight, then 18 with no drain
        bus(1'b1, 1'b0, 32'h00, 4'b0001, "t3_first", rd);
        wait_fall(t0, 8);
        for (int i = 1; i <= 16; i++) bus(1'b1, 1'b0, 32'(i), 4'b0001, "t3_fill", rd);
        bus(1'b0, 1'b1, 32'h0, 4'hF, "t3_full_status", rd);
        check("t3_full_bit", 32'(rd[20]), 32'd1);
        wait_drain("t3a", 4000);
        for (int i = 0; i < 18; i++) bus(1'b1, 1'b0, 32'h20 + 32'(i), 4'b0001, "t3_burst", rd);
        bus(1'b0, 1'b1, 32'h0, 4'hF, "t3_ovf_status", rd);
        check("t3_ovf_bit", 32'(rd[31]), 32'd1);
        bus(1'b1, 1'b1, 32'h8000_0000, 4'b1000, "t3_ovf_clear", rd);
        bus(1'b0, 1'b1, 32'h0, 4'hF, "t3_clr_status", rd);
        check("t3_ovf_cleared", 32'(rd[31]), 32'd0);
        wait_drain("t3b", 4000);

        // Divisor clamp and mid-frame change
        bus(1'b1, 1'b1, 32'd5, 4'b0011, "t4_div5", rd);
        bus(1'b0, 1'b1, 32'h0, 4'hF, "t4_status", rd);
        check("t4_clamp", 32'(rd[15:0]), 32'd16);
        bus(1'b1, 1'b0, 32'h3C, 4'b0001, "t4_push1", rd);
        wait_fall(t0, 8);
        wait_until(t0 + 40);
        bus(1'b1, 1'b1, 32'd32, 4'b0011, "t4_div32", rd);
        bus(1'b1, 1'b0, 32'hC3, 4'b0001, "t4_push2", rd);
        bus(1'b0, 1'b1, 32'h0, 4'hF, "t4_status32", rd);
        wait_drain("t4", 1000);

        // Push into a full FIFO on the cycle the serializer pops
        bus(1'b1, 1'b1, 32'd16, 4'b0011, "t5_div", rd);
        bus(1'b1, 1'b0, 32'h5A, 4'b0001, "t5_head", rd);
        wait_fall(t0, 8);
        for (int i = 0; i < 16; i++) bus(1'b1, 1'b0, 32'h60 + 32'(i), 4'b0001, "t5_fill", rd);
        wait_until(t0 + 159);
        bus(1'b1, 1'b0, 32'h99, 4'b0001, "t5_race", rd);
        bus(1'b0, 1'b1, 32'h0, 4'hF, "t5_status", rd);
        check("t5_count", 32'(rd[20:16]), 32'd15);
        bus(1'b1, 1'b1, 32'h8000_0000, 4'b1000, "t5_ovf_clear", rd);
        wait_drain("t5", 4000);

        // Reset in the middle of data bit 4
        bus(1'b1, 1'b0, 32'hA5, 4'b0001, "t6_push", rd);
        wait_fall(t0, 8);
        for (int i = 0; i < 3; i++) bus(1'b1, 1'b0, 32'h11 * 32'(i + 1), 4'b0001, "t6_more", rd);
        wait_until(t0 + 88);
        fb = {1'b1, 8'hA5, 1'b0};
        check("t6_bit4_line", 32'(o_uart_tx), 32'(fb[5]));
        mon_on = 1'b0;
        #2;
        i_resetn = 1'b0;
        #1;
        check("t6_async_tx", 32'(o_uart_tx), 32'd1);
        check("t6_async_irq", 32'(o_irq), 32'd1);
        repeat (2) @(negedge i_clk);
        model_reset();
        i_resetn = 1'b1;
        bus(1'b0, 1'b1, 32'h0, 4'hF, "t6_status", rd);
        check("t6_count", 32'(rd[20:16]), 32'd0);
        all_high = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge i_clk);
            if (o_uart_tx !== 1'b1) all_high = 1'b0;
        end
        check("t6_no_spurious", 32'(all_high), 32'd1);
        mon_on = 1'b1;
        bus(1'b1, 1'b1, 32'd16, 4'b0011, "t6_div", rd);
        bus(1'b1, 1'b0, 32'h7E, 4'b0001, "t6_recover", rd);
        wait_drain("t6", 400);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: begin
                    s = 4'($urandom);
                    if ($urandom_range(0, 3) != 0) s[0] = 1'b1;
                    bus(1'b1, 1'b0, $urandom, s, "rnd_data_wr", rd);
                end
                5, 6: bus(1'b0, 1'($urandom_range(0, 1)), $urandom, 4'($urandom), "rnd_rd", rd);
                7, 8: begin
                    d       = $urandom;
                    d[15:0] = 16'($urandom_range(0, 40));
                    s       = 4'($urandom);
                    if ($urandom_range(0, 1) != 0) s[1:0] = 2'b11;
                    bus(1'b1, 1'b1, d, s, "rnd_ctrl_wr", rd);
                end
                default: repeat ($urandom_range(1, 300)) @(negedge i_clk);
            endcase
        end
        wait_drain("rnd", 40000);
        bus(1'b0, 1'b1, 32'h0, 4'hF, "rnd_final_status", rd);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
